// File: rtl/output_module.sv
// output_module: CPU-side output block with four handshaked output ports.
// Each port latches a CPU write, raises strobe until the peripheral acks or
// a per-port timeout expires. Optional completion interrupt is enabled with
// the OUT_IRQ_EN macro; without it irq is tied low and no irq logic exists.
module output_module #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       sel_port,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       ack,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_p0,
  output logic [WIDTH-1:0] out_p1,
  output logic [WIDTH-1:0] out_p2,
  output logic [WIDTH-1:0] out_p3,
  output logic [3:0]       strobe,
  output logic             busy,
  output logic [3:0]       err,
  output logic             irq
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Counter value on the last PEND cycle before a forced release.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t           state     [4];
  state_t           state_nxt [4];
  logic [TW-1:0]    cnt       [4];
  logic [WIDTH-1:0] data_q    [4];

  logic [3:0] accept;    // write accepted into an IDLE port
  logic [3:0] ack_exit;  // PEND left because of ack
  logic [3:0] to_exit;   // PEND left because of timeout

  // Next-state and per-port event decode for all four port FSMs.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    accept   = '0;
    ack_exit = '0;
    to_exit  = '0;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE: begin
          if (we && (sel_port == i[1:0])) begin
            accept[i]    = 1'b1;
            state_nxt[i] = PEND;
          end
        end
        PEND: begin
          if (ack[i]) begin
            ack_exit[i]  = 1'b1;
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_LAST) begin
            to_exit[i]   = 1'b1;
            state_nxt[i] = IDLE;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Port state registers; reset discards any pending transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) state[i] <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < 4; i++) state[i] <= state_nxt[i];
    end
  end

  // Port data registers and timeout counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the small data register file is reset on purpose; outputs must read 0 after reset.
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          data_q[i] <= data_in;
          cnt[i]    <= '0;
        end else if (state[i] == PEND && cnt[i] != CNT_LAST) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Sticky timeout flags; a timeout on the clearing edge still sets its bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= '0;
    end else begin
      err <= (err_clr ? 4'b0000 : err) | to_exit;
    end
  end

`ifdef OUT_IRQ_EN
  // One-cycle completion pulse after any ack-terminated transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |ack_exit;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Output mapping.
  always_comb begin
    for (int i = 0; i < 4; i++) strobe[i] = (state[i] == PEND);
    busy = (state[sel_port] == PEND);
  end

  assign out_p0 = data_q[0];
  assign out_p1 = data_q[1];
  assign out_p2 = data_q[2];
  assign out_p3 = data_q[3];

endmodule

// File: tb/tb_output_module.sv
// tb_output_module: directed self-checking bench for output_module with a
// short timeout (TIMEOUT=4). irq expectations follow the OUT_IRQ_EN macro.
module tb_output_module;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 4;
  localparam int TW      = 8;

`ifdef OUT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             we;
  logic [1:0]       sel_port;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       ack;
  logic             err_clr;
  logic [WIDTH-1:0] out_p0, out_p1, out_p2, out_p3;
  logic [3:0]       strobe;
  logic             busy;
  logic [3:0]       err;
  logic             irq;

  int errors = 0;
  int checks = 0;

  output_module #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .sel_port (sel_port),
    .data_in  (data_in),
    .ack      (ack),
    .err_clr  (err_clr),
    .out_p0   (out_p0),
    .out_p1   (out_p1),
    .out_p2   (out_p2),
    .out_p3   (out_p3),
    .strobe   (strobe),
    .busy     (busy),
    .err      (err),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; ack = 4'b0000; err_clr = 1'b0; data_in = '0;
  endtask

  initial begin
    reset = 1'b0; sel_port = 2'd0;
    idle_inputs();
    tick(); tick();
    check("reset_strobe", 32'(strobe), 32'h0);
    check("reset_err",    32'(err),    32'h0);
    check("reset_irq",    32'(irq),    32'h0);
    check("reset_out_p2", 32'(out_p2), 32'h0);
    reset = 1'b1;
    tick();

    // 1: write A5 to port 2
    we = 1'b1; sel_port = 2'd2; data_in = 8'hA5;
    tick();
    we = 1'b0;
    check("t1_out_p2",  32'(out_p2), 32'hA5);
    check("t1_strobe",  32'(strobe), 32'b0100);
    check("t1_busy",    32'(busy),   32'h1);
    sel_port = 2'd0; #1;
    check("t1_busy_other_sel", 32'(busy), 32'h0);
    sel_port = 2'd2;

    // 2: ack port 2
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    check("t2_strobe", 32'(strobe), 32'h0);
    check("t2_err",    32'(err),    32'h0);
    check("t2_irq",    32'(irq),    32'(IRQ_ON));
    check("t2_out_p2", 32'(out_p2), 32'hA5);
    check("t2_busy",   32'(busy),   32'h0);
    tick();
    check("t2_irq_drop", 32'(irq), 32'h0);

    // ack while IDLE has no effect
    ack = 4'b1111;
    tick();
    ack = 4'b0000;
    check("idle_ack_strobe", 32'(strobe), 32'h0);
    check("idle_ack_irq",    32'(irq),    32'h0);

    // 3: port 1 timeout after exactly TIMEOUT PEND cycles
    we = 1'b1; sel_port = 2'd1; data_in = 8'h55;
    tick();
    we = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      check($sformatf("t3_strobe_pend%0d", i), 32'(strobe[1]), 32'h1);
      check($sformatf("t3_err_pend%0d", i),    32'(err),       32'h0);
      tick();
    end
    check("t3_strobe_fall", 32'(strobe), 32'h0);
    check("t3_err",         32'(err),    32'b0010);
    check("t3_irq",         32'(irq),    32'h0);
    tick();
    check("t3_irq_after",   32'(irq),    32'h0);
    check("t3_err_sticky",  32'(err),    32'b0010);

    // 3b: port 2 times out on the same edge as err_clr -> set wins, bit 1 clears
    we = 1'b1; sel_port = 2'd2; data_in = 8'h77;
    tick();
    we = 1'b0;
    tick(); tick(); tick();
    check("t3b_strobe_last", 32'(strobe), 32'b0100);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3b_err_set_wins", 32'(err),    32'b0100);
    check("t3b_strobe",       32'(strobe), 32'h0);
    check("t3b_out_p2",       32'(out_p2), 32'h77);

    // 4: writes to a PEND port are ignored, even alongside ack
    we = 1'b1; sel_port = 2'd0; data_in = 8'h99;
    tick();
    data_in = 8'h3C;
    tick();
    check("t4_ignored",      32'(out_p0), 32'h99);
    check("t4_busy",         32'(busy),   32'h1);
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    check("t4_ack_write_ignored", 32'(out_p0), 32'h99);
    check("t4_ack_strobe",        32'(strobe), 32'h0);
    check("t4_ack_irq",           32'(irq),    32'(IRQ_ON));
    tick();
    we = 1'b0;
    check("t4_retry_out_p0", 32'(out_p0), 32'h3C);
    check("t4_retry_strobe", 32'(strobe), 32'b0001);
    ack = 4'b0001;
    tick();
    ack = 4'b0000;
    check("t4_done_strobe", 32'(strobe), 32'h0);
    tick();

    // 5: ports 0 and 3 on consecutive cycles, joint ack -> one irq pulse
    we = 1'b1; sel_port = 2'd0; data_in = 8'h11;
    tick();
    sel_port = 2'd3; data_in = 8'h22;
    tick();
    we = 1'b0;
    check("t5_out_p0",  32'(out_p0), 32'h11);
    check("t5_out_p3",  32'(out_p3), 32'h22);
    check("t5_strobe",  32'(strobe), 32'b1001);
    ack = 4'b1001;
    tick();
    ack = 4'b0000;
    check("t5_strobe_fall", 32'(strobe), 32'h0);
    check("t5_irq",         32'(irq),    32'(IRQ_ON));
    tick();
    check("t5_irq_single",  32'(irq),    32'h0);
    check("t5_err",         32'(err),    32'b0100);

    // 6: async reset mid-transfer on port 1
    we = 1'b1; sel_port = 2'd1; data_in = 8'h7F;
    tick();
    we = 1'b0;
    check("t6_out_p1", 32'(out_p1), 32'h7F);
    check("t6_strobe", 32'(strobe), 32'b0010);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_strobe", 32'(strobe), 32'h0);
    check("t6_async_out_p1", 32'(out_p1), 32'h0);
    check("t6_async_err",    32'(err),    32'h0);
    check("t6_async_out_p0", 32'(out_p0), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_after_strobe", 32'(strobe), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
